// File: rtl/procesador_pkg.sv
// Shared constants, opcode-bit indices and FSM state encoding for the instruction sequencer.
// Included by pc_reg and pc_sequencer; holds no logic.
package procesador_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

  // Opcode bits seen by the jump-decision logic (B13/B12/B11)
  localparam int JMP_BIT = 13;
  localparam int COND_HI = 12;
  localparam int COND_LO = 11;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, increment wraps at 2^ADDR_W.
// One-cycle update latency; no flow control, the caller qualifies load_en/inc_en.
module pc_reg
  import procesador_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer holding PC, IR and carry; 3 cycles per instruction unstalled.
// Stalls in FETCH until mem_ready and in non-jump EXECUTE until exec_done; HALT is left only by reset.
module pc_sequencer
  import procesador_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  output logic               fetch_req,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  input  logic               pre_load,
  input  logic               exec_done,
  input  logic               alu_cy,
  input  logic               cy_we,
  output logic               CY,
  output logic               retire,
  output logic               halted,
  output logic [15:0]        retired_cnt
);

  seq_state_e         state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic               cy_d, cy_q;
  logic [15:0]        cnt_d, cnt_q;
  logic               pc_inc;
  logic               pc_load;

  pc_reg u_pc_reg (
    .clk      (CLK),
    .rst_n    (RST_N),
    .inc_en   (pc_inc),
    .load_en  (pc_load),
    .load_val (ir_q[ADDR_W-1:0]),
    .pc       (pc)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cy_d      = cy_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    fetch_req = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          ir_d = instr;
          if (instr == HALT_WORD) begin
            state_d = HALT;
          end else begin
            pc_inc  = 1'b1;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        state_d = EXECUTE;
      end
      EXECUTE: begin
        // pre_load is only looked at for jumps, so an unknown value elsewhere cannot leak
        if (ir_q[JMP_BIT]) begin
          pc_load = pre_load;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (exec_done) begin
          if (cy_we) begin
            cy_d = alu_cy;
          end
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    cnt_d = cnt_q + 16'(retire);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FETCH;
      ir_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ir          = ir_q;
  assign CY          = cy_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: straight-line code, jumps, carry, stalls, wrap, halt and async reset.
module tb_pc_sequencer;

  logic        CLK;
  logic        RST_N;
  logic [15:0] instr;
  logic        mem_ready;
  logic        fetch_req;
  logic [10:0] pc;
  logic [15:0] ir;
  logic        pre_load;
  logic        exec_done;
  logic        alu_cy;
  logic        cy_we;
  logic        CY;
  logic        retire;
  logic        halted;
  logic [15:0] retired_cnt;

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .instr       (instr),
    .mem_ready   (mem_ready),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .ir          (ir),
    .pre_load    (pre_load),
    .exec_done   (exec_done),
    .alu_cy      (alu_cy),
    .cy_we       (cy_we),
    .CY          (CY),
    .retire      (retire),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 2 time units past the edge
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic run3(input logic [15:0] w, input logic pl, input logic cw, input logic ac);
    instr     = w;
    mem_ready = 1'b1;
    exec_done = 1'b1;
    pre_load  = pl;
    cy_we     = cw;
    alu_cy    = ac;
    step();
    step();
    step();
  endtask

  initial begin
    RST_N = 1'b1; instr = '0; mem_ready = 1'b0; pre_load = 1'b0;
    exec_done = 1'b0; alu_cy = 1'b0; cy_we = 1'b0;
    #1 RST_N = 1'b0;
    #2;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_cy", 32'(CY), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cnt", 32'(retired_cnt), 32'h0);
    chk("rst_fetch_req", 32'(fetch_req), 32'h1);
    step();
    step();
    RST_N = 1'b1;

    // Straight-line code
    instr = 16'h0005; mem_ready = 1'b1; exec_done = 1'b1;
    step();
    chk("sl_dec_pc", 32'(pc), 32'h1);
    chk("sl_dec_ir", 32'(ir), 32'h0005);
    chk("sl_dec_fetch_req", 32'(fetch_req), 32'h0);
    chk("sl_dec_retire", 32'(retire), 32'h0);
    instr = 16'h0006;
    step();
    chk("sl_exe_retire", 32'(retire), 32'h1);
    chk("sl_exe_pc", 32'(pc), 32'h1);
    step();
    chk("sl_cnt1", 32'(retired_cnt), 32'h1);
    chk("sl_fetch_req", 32'(fetch_req), 32'h1);
    chk("sl_fetch_retire", 32'(retire), 32'h0);
    step();
    chk("sl2_dec_ir", 32'(ir), 32'h0006);
    step();
    chk("sl2_exe_retire", 32'(retire), 32'h1);
    step();
    chk("sl_pc2", 32'(pc), 32'h2);
    chk("sl_cnt2", 32'(retired_cnt), 32'h2);
    chk("sl_cy0", 32'(CY), 32'h0);

    // Carry write, then carry hold
    run3(16'h0007, 1'b0, 1'b1, 1'b1);
    chk("cy_set", 32'(CY), 32'h1);
    chk("cy_set_pc", 32'(pc), 32'h3);
    run3(16'h0008, 1'b0, 1'b0, 1'b0);
    chk("cy_hold", 32'(CY), 32'h1);
    chk("cy_hold_cnt", 32'(retired_cnt), 32'h4);

    // Taken jump; carry write request must be ignored
    instr = 16'h2123; pre_load = 1'b1; cy_we = 1'b1; alu_cy = 1'b0;
    step();
    chk("jmp_dec_pc", 32'(pc), 32'h5);
    step();
    chk("jmp_exe_retire", 32'(retire), 32'h1);
    step();
    chk("jmp_taken_pc", 32'(pc), 32'h123);
    chk("jmp_cy_kept", 32'(CY), 32'h1);
    chk("jmp_cnt", 32'(retired_cnt), 32'h5);

    // Not-taken jump
    run3(16'h2123, 1'b0, 1'b0, 1'b0);
    chk("jmp_nt_pc", 32'(pc), 32'h124);
    chk("jmp_nt_cnt", 32'(retired_cnt), 32'h6);

    // Non-jump with pre_load high outside EXECUTE and unknown inside it
    instr = 16'h0009; pre_load = 1'b1;
    step();
    chk("nj_dec_pc", 32'(pc), 32'h125);
    pre_load = 1'bx;
    step();
    step();
    chk("nj_pl_pc", 32'(pc), 32'h125);
    chk("nj_pl_ir", 32'(ir), 32'h0009);
    chk("nj_pl_cnt", 32'(retired_cnt), 32'h7);

    // Tight loop: target equals the instruction's own address
    run3(16'h2125, 1'b1, 1'b0, 1'b0);
    chk("tight_pc", 32'(pc), 32'h125);
    chk("tight_cnt", 32'(retired_cnt), 32'h8);

    // Memory stall then datapath stall
    pre_load = 1'b0; instr = 16'h000A; mem_ready = 1'b0; exec_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mstall_pc", 32'(pc), 32'h125);
      chk("mstall_ir", 32'(ir), 32'h2125);
      chk("mstall_fetch_req", 32'(fetch_req), 32'h1);
    end
    mem_ready = 1'b1;
    step();
    chk("stall_dec_pc", 32'(pc), 32'h126);
    chk("stall_dec_ir", 32'(ir), 32'h000A);
    instr = 16'h0BAD;
    step();
    chk("xstall0_retire", 32'(retire), 32'h0);
    step();
    chk("xstall1_retire", 32'(retire), 32'h0);
    chk("xstall_ir", 32'(ir), 32'h000A);
    chk("xstall_pc", 32'(pc), 32'h126);
    exec_done = 1'b1;
    #1;
    chk("xstall_done_retire", 32'(retire), 32'h1);
    step();
    chk("stall_cnt", 32'(retired_cnt), 32'h9);

    // PC wrap
    run3(16'h27FF, 1'b1, 1'b0, 1'b0);
    chk("wrap_pre_pc", 32'(pc), 32'h7FF);
    run3(16'h000B, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_cnt", 32'(retired_cnt), 32'hB);
    run3(16'h000C, 1'b0, 1'b0, 1'b0);
    chk("post_wrap_pc", 32'(pc), 32'h1);

    // Halt
    instr = 16'hFFFF; mem_ready = 1'b1;
    step();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_fetch_req", 32'(fetch_req), 32'h0);
    chk("halt_pc", 32'(pc), 32'h1);
    chk("halt_ir", 32'(ir), 32'hFFFF);
    instr = 16'h0005; exec_done = 1'b1; pre_load = 1'b1; cy_we = 1'b1; alu_cy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_frozen_pc", 32'(pc), 32'h1);
      chk("halt_stays", 32'(halted), 32'h1);
    end
    chk("halt_cnt", 32'(retired_cnt), 32'hC);
    chk("halt_cy", 32'(CY), 32'h1);
    chk("halt_retire", 32'(retire), 32'h0);

    #1 RST_N = 1'b0;
    #1;
    chk("hrst_pc", 32'(pc), 32'h0);
    chk("hrst_halted", 32'(halted), 32'h0);
    chk("hrst_fetch_req", 32'(fetch_req), 32'h1);
    chk("hrst_cnt", 32'(retired_cnt), 32'h0);
    RST_N = 1'b1;

    run3(16'h0001, 1'b0, 1'b1, 1'b1);
    chk("post_hrst_pc", 32'(pc), 32'h1);
    chk("post_hrst_cy", 32'(CY), 32'h1);

    // Async reset in the middle of a stalled EXECUTE
    instr = 16'h0003; exec_done = 1'b0; cy_we = 1'b0;
    step();
    step();
    chk("mid_exe_retire", 32'(retire), 32'h0);
    exec_done = 1'b1; cy_we = 1'b1; alu_cy = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    chk("mrst_pc", 32'(pc), 32'h0);
    chk("mrst_ir", 32'(ir), 32'h0);
    chk("mrst_cy", 32'(CY), 32'h0);
    chk("mrst_cnt", 32'(retired_cnt), 32'h0);
    chk("mrst_retire", 32'(retire), 32'h0);
    chk("mrst_halted", 32'(halted), 32'h0);
    chk("mrst_fetch_req", 32'(fetch_req), 32'h1);
    step();
    chk("mrst_edge_cy", 32'(CY), 32'h0);
    chk("mrst_edge_pc", 32'(pc), 32'h0);
    RST_N = 1'b1;
    run3(16'h0004, 1'b0, 1'b0, 1'b0);
    chk("recover_pc", 32'(pc), 32'h1);
    chk("recover_ir", 32'(ir), 32'h0004);
    chk("recover_cnt", 32'(retired_cnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
